// File: rtl/response_encoder.sv
// Turns read/write completions into ASCII response lines ("<hex>\n" or "ok\n")
// streamed one byte per handshake on an AXI-Stream master port.
module response_encoder #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rd_done,
  input  logic [WORD_SIZE-1:0] Rdata,
  input  logic                 Wr_done,
  output logic                 M_axis_tvalid,
  output logic [7:0]           M_axis_tdata,
  input  logic                 M_axis_tready,
  output logic                 Busy,
  output logic                 Overflow
);

  localparam int NDIG = WORD_SIZE / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HEX,
    SEND_OK,
    SEND_NL
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] shreg, shreg_nxt;
  logic [CW-1:0]        dig_cnt, dig_cnt_nxt;
  logic                 ok_idx, ok_idx_nxt;
  logic                 overflow_nxt;
  logic                 hs;
  logic [3:0]           nibble;

  assign M_axis_tvalid = (state != IDLE);
  assign Busy          = (state != IDLE);
  assign hs            = M_axis_tvalid & M_axis_tready;
  assign nibble        = shreg[WORD_SIZE-1 -: 4];

  // Output byte is decoded only from registered state, so tready and the
  // completion pulses never reach tdata/tvalid combinationally.
  always_comb begin
    M_axis_tdata = '0;
    case (state)
      SEND_HEX: M_axis_tdata = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                                : (8'h57 + {4'h0, nibble});
      SEND_OK:  M_axis_tdata = ok_idx ? 8'h6B : 8'h6F;
      SEND_NL:  M_axis_tdata = 8'h0A;
      default:  M_axis_tdata = '0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    dig_cnt_nxt  = dig_cnt;
    ok_idx_nxt   = ok_idx;
    overflow_nxt = Overflow;

    case (state)
      IDLE: begin
        if (Rd_done) begin
          shreg_nxt   = Rdata;
          dig_cnt_nxt = CW'(NDIG - 1);
          state_nxt   = SEND_HEX;
          if (Wr_done) overflow_nxt = 1'b1;
        end else if (Wr_done) begin
          ok_idx_nxt = 1'b0;
          state_nxt  = SEND_OK;
        end
      end
      SEND_HEX: begin
        if (hs) begin
          shreg_nxt = shreg << 4;
          if (dig_cnt == '0) state_nxt = SEND_NL;
          else               dig_cnt_nxt = dig_cnt - CW'(1);
        end
      end
      SEND_OK: begin
        if (hs) begin
          if (ok_idx) state_nxt = SEND_NL;
          else        ok_idx_nxt = 1'b1;
        end
      end
      SEND_NL: begin
        if (hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && (Rd_done || Wr_done)) overflow_nxt = 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      shreg    <= '0;
      dig_cnt  <= '0;
      ok_idx   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      dig_cnt  <= dig_cnt_nxt;
      ok_idx   <= ok_idx_nxt;
      Overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_response_encoder.sv
// Randomized self-checking bench for response_encoder; expected byte streams
// come from formatting the word as text, not from any model of the FSM.
module tb_response_encoder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_done;
  logic [W-1:0] rdata;
  logic         wr_done;
  logic         tvalid;
  logic [7:0]   tdata;
  logic         tready;
  logic         busy;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];

  response_encoder #(.WORD_SIZE(W)) dut (
    .Clk           (clk),
    .Rst           (rst),
    .Rd_done       (rd_done),
    .Rdata         (rdata),
    .Wr_done       (wr_done),
    .M_axis_tvalid (tvalid),
    .M_axis_tdata  (tdata),
    .M_axis_tready (tready),
    .Busy          (busy),
    .Overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic expect_read(input logic [W-1:0] w);
    string s;
    s = $sformatf("%h", w);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic expect_write();
    exp_q.delete();
    exp_q.push_back("o");
    exp_q.push_back("k");
    exp_q.push_back(8'h0A);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic pulse_read(input logic [W-1:0] w, input bit also_wr);
    rd_done = 1'b1;
    rdata   = w;
    wr_done = also_wr;
    @(posedge clk); @(negedge clk);
    rd_done = 1'b0;
    wr_done = 1'b0;
  endtask

  task automatic pulse_write();
    wr_done = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_done = 1'b0;
  endtask

  // Gathers handshaken bytes until the line feed; can inject a stray Wr_done.
  task automatic collect(input int max_cycles, input bit rand_ready, input int inject_at,
                         output int cycles, output int stall_bad, output bit timeout);
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         done;
    got_q.delete();
    cycles     = 0;
    stall_bad  = 0;
    timeout    = 1'b1;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < max_cycles; c++) begin
      wr_done = (c == inject_at);
      if (prev_stall && (!tvalid || tdata !== prev_data)) stall_bad++;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycles++;
      if (tvalid && tready) got_q.push_back(tdata);
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      done       = tvalid && tready && (tdata == 8'h0A);
      @(posedge clk); @(negedge clk);
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    wr_done = 1'b0;
    tready  = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 8'h00)   begin errors++; $display("FAIL reset_tdata got=%h exp=00", tdata); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_read();
    logic [W-1:0] w;
    int cyc, sb;
    bit to;
    for (int n = 0; n < 6; n++) begin
      w = (n == 0) ? 32'hDEADBEEF : ((n == 1) ? 32'h00000000 : $urandom);
      expect_read(w);
      pulse_read(w, 1'b0);
      collect(40, 1'b0, -1, cyc, sb, to);
      checks++; if (to) begin errors++; $display("FAIL read_timeout word=%h got=timeout exp=frame", w); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL read_len word=%h got=%0d exp=%0d", w, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL read_byte word=%h idx=%0d got=%h exp=%h", w, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
      end
      checks++; if (cyc != 9)         begin errors++; $display("FAIL read_cycles word=%h got=%0d exp=9", w, cyc); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL read_busy_after got=%b exp=0", busy); end
      checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL read_tvalid_after got=%b exp=0", tvalid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL read_overflow got=%b exp=0", overflow); end
    end
  endtask

  task automatic test_write();
    int cyc, sb;
    bit to;
    expect_write();
    pulse_write();
    collect(20, 1'b0, -1, cyc, sb, to);
    checks++; if (to || got_q.size() != 3) begin errors++; $display("FAIL write_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL write_byte idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (cyc != 3)         begin errors++; $display("FAIL write_cycles got=%0d exp=3", cyc); end
    checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL write_tvalid_after got=%b exp=0", tvalid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL write_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    int cyc, sb;
    bit to;
    for (int n = 0; n < 5; n++) begin
      w = (n == 0) ? 32'h0123ABCF : $urandom;
      expect_read(w);
      pulse_read(w, 1'b0);
      collect(200, 1'b1, -1, cyc, sb, to);
      checks++; if (to) begin errors++; $display("FAIL bp_timeout word=%h got=timeout exp=frame", w); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len word=%h got=%0d exp=%0d", w, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL bp_byte word=%h idx=%0d got=%h exp=%h", w, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
      end
      checks++; if (sb != 0) begin errors++; $display("FAIL bp_stall_stable word=%h got=%0d exp=0 violations", w, sb); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got=%b exp=0", overflow); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, sb;
    bit to;
    expect_write();
    pulse_write();
    collect(20, 1'b0, -1, cyc, sb, to);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got=%b exp=0", busy); end
    pulse_write();
    collect(20, 1'b0, -1, cyc, sb, to);
    checks++; if (to || got_q.size() != 3) begin errors++; $display("FAIL b2b_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_byte idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (cyc != 3)         begin errors++; $display("FAIL b2b_cycles got=%0d exp=3", cyc); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_collision();
    logic [W-1:0] w;
    int cyc, sb;
    bit to;
    bit saw_valid;
    w = $urandom;
    expect_read(w);
    pulse_read(w, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coll_overflow_rise got=%b exp=1", overflow); end
    collect(40, 1'b0, -1, cyc, sb, to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL coll_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL coll_byte idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    saw_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (tvalid) saw_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL coll_no_write_frame got=tvalid exp=idle"); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coll_overflow got=%b exp=1", overflow); end

    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coll_overflow_clear got=%b exp=0", overflow); end

    w = $urandom;
    expect_read(w);
    pulse_read(w, 1'b0);
    collect(40, 1'b0, 3, cyc, sb, to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mid_byte idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_overflow got=%b exp=1", overflow); end
    checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL mid_tvalid_after got=%b exp=0", tvalid); end
  endtask

  task automatic test_reset_mid_frame();
    int cyc, sb;
    bit to;
    tready = 1'b1;
    pulse_read($urandom, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL rstmid_tvalid got=%b exp=0", tvalid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (tdata !== 8'h00)   begin errors++; $display("FAIL rstmid_tdata got=%h exp=00", tdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_write();
    pulse_write();
    collect(20, 1'b0, -1, cyc, sb, to);
    checks++; if (to || got_q.size() != 3) begin errors++; $display("FAIL rstmid_ok_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_ok_byte idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (cyc != 3) begin errors++; $display("FAIL rstmid_ok_cycles got=%0d exp=3", cyc); end
  endtask

  initial begin
    rst     = 1'b1;
    rd_done = 1'b0;
    wr_done = 1'b0;
    rdata   = '0;
    tready  = 1'b1;
    @(negedge clk); @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_read();
    test_write();
    test_backpressure();
    test_back_to_back();
    test_collision();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
